// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback trace encoder: record layout and channel bundle.
package wb_trace_pkg;

  localparam logic [31:0] DEFAULT_END_PC = 32'hbfc00100;

  // One emitted trace record, same layout the golden-trace comparator consumes.
  typedef struct packed {
    logic        cmp_flag;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } trace_rec_t;

  // One writeback channel as seen at the datapath boundary.
  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] pc;
  } wb_chan_t;

  function automatic trace_rec_t make_rec(input wb_chan_t ch, input logic flag);
    trace_rec_t r;
    r.cmp_flag = flag;
    r.pc       = ch.pc;
    r.rd       = ch.rd;
    r.wdata    = ch.wdata;
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Two-write / one-read FIFO. Port B writes the slot after port A in the same
// cycle; the caller only asserts push_b_i together with push_a_i and only when
// free_o leaves room for every write it issues.
module trace_fifo_2w1r
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_a_i,
  input  trace_rec_t              data_a_i,
  input  logic                    push_b_i,
  input  trace_rec_t              data_b_i,
  input  logic                    pop_i,
  output trace_rec_t              head_o,
  output logic [$clog2(DEPTH):0]  occupancy_o,
  output logic [$clog2(DEPTH):0]  free_o
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [AW-1:0] waddr_b;
  logic          pop;

  assign pop         = pop_i && (occ_q != '0);
  assign waddr_b     = wptr_q + AW'(1);
  // A pop in the same cycle frees its slot for this cycle's writes.
  assign free_o      = (AW+1)'(DEPTH) - occ_q + (AW+1)'(pop);
  assign occupancy_o = occ_q;
  // Head reads as zero while empty so outputs are clean straight after reset.
  assign head_o      = (occ_q != '0) ? mem_q[rptr_q] : '0;

  // Next-state for pointers and occupancy: up to two writes and one read per cycle.
  always_comb begin
    wptr_d = wptr_q + AW'(push_a_i) + AW'(push_b_i);
    rptr_d = rptr_q + AW'(pop);
    occ_d  = occ_q + (AW+1)'(push_a_i) + (AW+1)'(push_b_i) - (AW+1)'(pop);
  end

  // Control state register; storage contents are not reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Storage writes: port A at wptr, port B at the following slot.
  always_ff @(posedge clk_i) begin
    if (push_a_i) mem_q[wptr_q]  <= data_a_i;
    if (push_b_i) mem_q[waddr_b] <= data_b_i;
  end

endmodule

// File: rtl/wb_trace_encoder.sv
// Writeback trace encoder: filters the two writeback channels into in-order
// trace records, stops at the end-of-test PC and stops pushing on the first
// lost record so the emitted stream is always a contiguous prefix.
module wb_trace_encoder
  import wb_trace_pkg::*;
#(
  parameter int          DEPTH  = 16,
  parameter logic [31:0] END_PC = DEFAULT_END_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb0_en,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_wdata,
  input  logic [31:0] wb0_pc,
  input  logic        wb1_en,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_wdata,
  input  logic [31:0] wb1_pc,
  input  logic        open_trace,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic        trace_cmp_flag,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_rd,
  output logic [31:0] trace_wdata,
  output logic        overflow,
  output logic        done,
  output logic [31:0] rec_count
);

  localparam int AW = $clog2(DEPTH);

  wb_chan_t    ch0, ch1;
  trace_rec_t  rec0, rec1, data_a, data_b, head;
  logic        hit0, hit1, cand0, cand1;
  logic        push_a, push_b, pop;
  logic [AW:0] occupancy, free_slots;
  logic        overflow_q, overflow_d;
  logic        done_q, done_d;
  logic [31:0] rec_count_q, rec_count_d;

  assign ch0  = {wb0_en, wb0_rd, wb0_wdata, wb0_pc};
  assign ch1  = {wb1_en, wb1_rd, wb1_wdata, wb1_pc};
  assign rec0 = make_rec(ch0, open_trace);
  assign rec1 = make_rec(ch1, open_trace);

  assign trace_valid = (occupancy != '0);
  assign pop         = trace_valid && trace_ready;

  // Candidate filtering, END_PC handling and the push/overflow policy.
  always_comb begin
    hit0        = wb0_en && (wb0_pc == END_PC);
    hit1        = wb1_en && (wb1_pc == END_PC);
    // Channel 0 hitting END_PC also kills the younger channel 1.
    cand0       = wb0_en && (wb0_rd != '0) && !done_q && !overflow_q && !hit0;
    cand1       = wb1_en && (wb1_rd != '0) && !done_q && !overflow_q && !hit1 && !hit0;
    push_a      = 1'b0;
    push_b      = 1'b0;
    overflow_d  = overflow_q;
    data_a      = cand0 ? rec0 : rec1;
    data_b      = rec1;
    unique case ({cand0, cand1})
      2'b11: begin
        if (free_slots >= (AW+1)'(2)) begin
          push_a = 1'b1;
          push_b = 1'b1;
        end else if (free_slots == (AW+1)'(1)) begin
          push_a     = 1'b1;
          overflow_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      2'b10, 2'b01: begin
        if (free_slots != '0) push_a = 1'b1;
        else                  overflow_d = 1'b1;
      end
      default: ;
    endcase
    done_d      = done_q || hit0 || hit1;
    rec_count_d = rec_count_q + 32'(pop);
  end

  // Sticky status flags and the hand-off counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      rec_count_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      rec_count_q <= rec_count_d;
    end
  end

  trace_fifo_2w1r #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_a_i    (push_a),
    .data_a_i    (data_a),
    .push_b_i    (push_b),
    .data_b_i    (data_b),
    .pop_i       (pop),
    .head_o      (head),
    .occupancy_o (occupancy),
    .free_o      (free_slots)
  );

  assign trace_cmp_flag = head.cmp_flag;
  assign trace_pc       = head.pc;
  assign trace_rd       = head.rd;
  assign trace_wdata    = head.wdata;
  assign overflow       = overflow_q;
  assign done           = done_q;
  assign rec_count      = rec_count_q;

endmodule
